// File: rtl/conv_stream_engine.sv
// Streaming KxK convolution: raster pixels in, one result per fully covered window, 2-stage MAC pipeline.
// Optional feature: define CONV_RELU_EN to clamp negative results to zero.
module conv_stream_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28,
  parameter int FRAC_BITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  coef_valid,
  input  logic [DATA_WIDTH-1:0] coef_in,
  output logic                  coef_done,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_in,
  output logic                  pix_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic                  frame_done
);
  localparam int KK   = KERNEL_SIZE * KERNEL_SIZE;
  // The incoming pixel is the newest window tap, so only the older taps are stored.
  localparam int LB_N = (KERNEL_SIZE - 1) * IMG_WIDTH + KERNEL_SIZE - 1;
  localparam int CIW  = $clog2(KK + 1) + 1;
  localparam int CW   = $clog2(IMG_WIDTH);
  localparam int RW   = $clog2(IMG_HEIGHT);
  localparam int PW   = 2 * DATA_WIDTH;
  localparam int AW   = PW + $clog2(KK + 1);
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic {ST_LOAD = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic [CIW-1:0]                cidx_q;
  logic                          coef_done_q;
  logic signed [DATA_WIDTH-1:0]  w_q [KK];
  logic signed [DATA_WIDTH-1:0]  bias_q;
  logic [CW-1:0]                 col_q;
  logic [RW-1:0]                 row_q;
  logic signed [DATA_WIDTH-1:0]  lb_q [LB_N];
  logic signed [DATA_WIDTH-1:0]  tapv_s [LB_N+1];
  logic signed [PW-1:0]          prod_d [KK];
  logic signed [PW-1:0]          prod_q [KK];
  logic                          v1_q, last1_q;
  logic                          out_valid_q, last2_q;
  logic [DATA_WIDTH-1:0]         out_data_q;
  logic signed [AW-1:0]          acc_s, shr_s;
  logic [DATA_WIDTH-1:0]         res_s, result_s;
  logic                          adv_s, pix_acc_s, coef_acc_s, bias_hit_s, win_ok_s, last_pix_s;

  assign adv_s      = !out_valid_q | out_ready;
  assign pix_ready  = (state_q == ST_RUN) & adv_s;
  assign pix_acc_s  = pix_valid & pix_ready & !load_start;
  assign coef_acc_s = (state_q == ST_LOAD) & coef_valid & !load_start;
  assign bias_hit_s = coef_acc_s & (cidx_q == CIW'(KK));
  assign win_ok_s   = (row_q >= RW'(KERNEL_SIZE - 1)) & (col_q >= CW'(KERNEL_SIZE - 1));
  assign last_pix_s = (row_q == RW'(IMG_HEIGHT - 1)) & (col_q == CW'(IMG_WIDTH - 1));

  assign coef_done  = coef_done_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign frame_done = out_valid_q & out_ready & last2_q;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: load_start dominates, bias write moves to RUN
  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = ST_LOAD;
    end else if (bias_hit_s) begin
      state_d = ST_RUN;
    end else begin
      state_d = state_q;
    end
  end

  // Coefficient capture: weights in raster order, then bias
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cidx_q      <= '0;
      coef_done_q <= 1'b0;
      bias_q      <= '0;
      for (int i = 0; i < KK; i++) w_q[i] <= '0;
    end else if (load_start) begin
      cidx_q      <= '0;
      coef_done_q <= 1'b0;
    end else if (coef_acc_s) begin
      cidx_q <= cidx_q + CIW'(1);
      if (cidx_q < CIW'(KK)) begin
        w_q[cidx_q] <= coef_in;
      end else begin
        bias_q      <= coef_in;
        coef_done_q <= 1'b1;
      end
    end
  end

  // Line buffer shift and raster position counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
      for (int n = 0; n < LB_N; n++) lb_q[n] <= '0;
    end else if (load_start) begin
      col_q <= '0;
      row_q <= '0;
    end else if (pix_acc_s) begin
      lb_q[0] <= pix_in;
      for (int n = 1; n < LB_N; n++) lb_q[n] <= lb_q[n-1];
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_q <= '0;
        row_q <= (row_q == RW'(IMG_HEIGHT - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Window taps: tap d*W+c holds the pixel d rows up and c columns left of the newest one
  always_comb begin
    tapv_s[0] = pix_in;
    for (int n = 1; n <= LB_N; n++) tapv_s[n] = lb_q[n-1];
  end

  // Stage 1 products; weight (i,j) pairs with the window's top-left-relative pixel (i,j)
  always_comb begin
    for (int i = 0; i < KERNEL_SIZE; i++) begin
      for (int j = 0; j < KERNEL_SIZE; j++) begin
        prod_d[i*KERNEL_SIZE+j] = w_q[i*KERNEL_SIZE+j] *
                                  tapv_s[(KERNEL_SIZE-1-i)*IMG_WIDTH + (KERNEL_SIZE-1-j)];
      end
    end
  end

  // Stage 2 sum, rescale (floor) and saturate
  always_comb begin
    acc_s = $signed({{(AW-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q}) <<< FRAC_BITS;
    for (int t = 0; t < KK; t++) begin
      acc_s = acc_s + $signed({{(AW-PW){prod_q[t][PW-1]}}, prod_q[t]});
    end
    shr_s = acc_s >>> FRAC_BITS;
    if (shr_s > SAT_MAX) begin
      res_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (shr_s < SAT_MIN) begin
      res_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res_s = shr_s[DATA_WIDTH-1:0];
    end
`ifdef CONV_RELU_EN
    result_s = res_s[DATA_WIDTH-1] ? {DATA_WIDTH{1'b0}} : res_s;
`else
    result_s = res_s;
`endif
  end

  // Pipeline registers; everything holds while the output is stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      last2_q     <= 1'b0;
      out_data_q  <= '0;
      for (int t = 0; t < KK; t++) prod_q[t] <= '0;
    end else if (load_start) begin
      v1_q        <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv_s) begin
      v1_q        <= pix_acc_s & win_ok_s;
      last1_q     <= last_pix_s;
      out_valid_q <= v1_q;
      last2_q     <= last1_q;
      if (pix_acc_s) begin
        for (int t = 0; t < KK; t++) prod_q[t] <= prod_d[t];
      end
      if (v1_q) begin
        out_data_q <= result_s;
      end
    end
  end
endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine (K=3, 5x5 frames, 4 fraction bits) with a frame-level reference model.
module tb_conv_stream_engine;
  localparam int DW = 16, K = 3, W = 5, H = 5, F = 4;

  logic clk = 1'b0;
  logic reset, load_start, coef_valid, pix_valid, out_ready;
  logic coef_done, pix_ready, out_valid, frame_done;
  logic [DW-1:0] coef_in, pix_in, out_data;

  always #5 clk = ~clk;

  conv_stream_engine #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FRAC_BITS(F)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .coef_valid(coef_valid), .coef_in(coef_in),
    .coef_done(coef_done), .pix_valid(pix_valid), .pix_in(pix_in), .pix_ready(pix_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .frame_done(frame_done));

  int checks = 0, failures = 0;
  int exp_val[$];
  bit exp_last[$];
  int mw[K*K];
  int mb;
  int img[H][W];
  int mr, mc;
  int pix_src[W*H];
  int rdy_mode, gap_max, out_cnt, last_out;
  logic stall_prev = 1'b0;
  logic [DW-1:0] data_prev;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: floor((bias*2^F + sum w*p) / 2^F), saturated, optionally clamped at 0
  function automatic int ref_conv(input int r, input int c);
    longint s, q;
    s = longint'(mb) * (64'sd1 << F);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        s += longint'(mw[i*K+j]) * longint'(img[r-K+1+i][c-K+1+j]);
    q = s / (64'sd1 << F);
    if (s < 0 && (s % (64'sd1 << F)) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
`ifdef CONV_RELU_EN
    if (q < 0) q = 0;
`endif
    return int'(q);
  endfunction

  task automatic model_accept(input int v);
    img[mr][mc] = v;
    if (mr >= K-1 && mc >= K-1) begin
      exp_val.push_back(ref_conv(mr, mc));
      exp_last.push_back(mr == H-1 && mc == W-1);
    end
    if (mc == W-1) begin
      mc = 0;
      mr = (mr == H-1) ? 0 : mr + 1;
    end else mc++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_model();
    exp_val.delete();
    exp_last.delete();
    mr = 0;
    mc = 0;
  endtask

  task automatic load_coefs();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    flush_model();
    chk("coef_done_cleared", coef_done, 0);
    for (int n = 0; n <= K*K; n++) begin
      coef_valid = 1'b0;
      repeat ($urandom_range(0, 1)) tick();
      coef_in = (n < K*K) ? mw[n] : mb;
      coef_valid = 1'b1;
      tick();
    end
    coef_valid = 1'b0;
    chk("coef_done_set", coef_done, 1);
  endtask

  task automatic send_pixels(input int n);
    bit acc;
    int waited;
    for (int idx = 0; idx < n; idx++) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) tick();
      pix_valid = 1'b1;
      pix_in = pix_src[idx];
      acc = 1'b0;
      waited = 0;
      while (!acc && waited < 300) begin
        @(negedge clk);
        acc = pix_ready;
        tick();
        waited++;
      end
      if (acc) model_accept(pix_src[idx]);
      else begin
        checks++; failures++;
        $display("FAIL pix_accept_timeout actual=not_ready required=accepted idx=%0d", idx);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while (exp_val.size() > 0 && waited < 1000) begin
      tick();
      waited++;
    end
    if (exp_val.size() > 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_val.size());
      flush_model();
    end
  endtask

  task automatic run_frame();
    int start = out_cnt;
    send_pixels(W*H);
    drain();
    chk("outputs_per_frame", out_cnt - start, (H-K+1)*(W-K+1));
  endtask

  // Downstream ready: 0 = always ready, 1 = random backpressure, 2 = stalled
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares every transfer against the scoreboard and checks stall stability
  initial begin
    forever begin
      @(negedge clk);
      if (reset) stall_prev = 1'b0;
      else begin
        if (stall_prev) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", $signed(out_data), $signed(data_prev));
        end
        if (out_valid && out_ready) begin
          if (exp_val.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_output actual=%0d required=none", $signed(out_data));
          end else begin
            chk("out_data", $signed(out_data), exp_val.pop_front());
            chk("frame_done", frame_done, int'(exp_last.pop_front()));
          end
          last_out = $signed(out_data);
          out_cnt++;
        end else if (out_valid) chk("frame_done_idle", frame_done, 0);
        stall_prev = out_valid && !out_ready && !load_start;
        data_prev = out_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; load_start = 1'b0; coef_valid = 1'b0; coef_in = '0;
    pix_valid = 1'b0; pix_in = '0; rdy_mode = 0; gap_max = 0; out_cnt = 0; last_out = 0;
    mr = 0; mc = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_coef_done", coef_done, 0);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    tick();
    reset = 1'b0;
    tick();

    // Unit weights (1.0 in Q.4), pixels 1..25
    for (int i = 0; i < K*K; i++) mw[i] = 16;
    mb = 0;
    for (int i = 0; i < W*H; i++) pix_src[i] = i + 1;
    load_coefs();
    run_frame();
    chk("unit_last", last_out, 171);

    // Stall at the first output for four cycles
    rdy_mode = 2;
    fork
      send_pixels(W*H);
      begin
        w = 0;
        do begin @(negedge clk); w++; end while (!out_valid && w < 200);
        chk("stall_first_valid", out_valid, 1);
        repeat (4) begin
          @(negedge clk);
          chk("stall_pix_ready", pix_ready, 0);
          chk("stall_data", $signed(out_data), 63);
        end
        rdy_mode = 0;
      end
    join
    drain();
    chk("stall_last", last_out, 171);

    // Zero weights, bias -5.0
    for (int i = 0; i < K*K; i++) mw[i] = 0;
    mb = -80;
    load_coefs();
    run_frame();
`ifdef CONV_RELU_EN
    chk("bias_only", last_out, 0);
`else
    chk("bias_only", last_out, -80);
`endif

    // Saturation both ways
    for (int i = 0; i < W*H; i++) pix_src[i] = 32767;
    for (int i = 0; i < K*K; i++) mw[i] = 32767;
    mb = 0;
    load_coefs();
    run_frame();
    chk("sat_pos", last_out, 32767);
    for (int i = 0; i < K*K; i++) mw[i] = -32768;
    load_coefs();
    run_frame();
`ifdef CONV_RELU_EN
    chk("sat_neg", last_out, 0);
`else
    chk("sat_neg", last_out, -32768);
`endif

    // Reload after 12 pixels: centre-only kernel selects the window centre
    for (int i = 0; i < W*H; i++) pix_src[i] = i + 1;
    for (int i = 0; i < K*K; i++) mw[i] = 16;
    load_coefs();
    send_pixels(12);
    for (int i = 0; i < K*K; i++) mw[i] = 0;
    mw[4] = 16;
    load_coefs();
    run_frame();
    chk("centre_last", last_out, 19);

    // Reset mid-frame after 20 pixels
    for (int i = 0; i < K*K; i++) mw[i] = 16;
    load_coefs();
    send_pixels(20);
    reset = 1'b1;
    flush_model();
    tick();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_coef_done", coef_done, 0);
    reset = 1'b0;
    repeat (10) tick();
    chk("midrst_pix_ready", pix_ready, 0);
    load_coefs();
    run_frame();
    chk("midrst_last", last_out, 171);

    // Randomized frames with backpressure and input gaps; the last one uses full-range values
    rdy_mode = 1;
    gap_max = 2;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < K*K; i++)
        mw[i] = (f == 3) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 127)) - 64;
      mb = int'($urandom_range(0, 1023)) - 512;
      for (int i = 0; i < W*H; i++)
        pix_src[i] = (f == 3) ? int'($urandom_range(0, 65535)) - 32768 : int'($urandom_range(0, 4095)) - 2048;
      load_coefs();
      run_frame();
    end
    rdy_mode = 0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
